// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad-driven sequencer for the 4-bit add/sub calculator datapath.
// Collects operand A, operator and operand B, presents them to the external datapath,
// then captures the 6-bit two's-complement result into a held display register.
// Optional feature: define CALC_TIMEOUT_EN to clear an abandoned entry after TO_CYCLES
// idle cycles in S_OP/S_B.
module calc_seq_ctrl #(
  parameter int unsigned TO_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [5:0] res_in,
  output logic [3:0] a_data,
  output logic [3:0] b_data,
  output logic       op_sel,
  output logic [5:0] result,
  output logic       res_valid,
  output logic       neg,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // Elaboration guard: the timeout needs at least two idle cycles to be meaningful
  if (TO_CYCLES < 2) begin : g_to_check
    $error("calc_seq_ctrl: TO_CYCLES must be >= 2");
  end

  state_t     state_q, state_n;
  logic [3:0] a_n, b_n;
  logic       op_n, b_set, b_set_n;
  logic [5:0] result_n;
  logic       res_valid_n, neg_n;

  logic key_digit, key_op, key_eq, key_clr, clear_c;

  // Key classification; 0xC/0xD fall into no class and are therefore ignored
  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_op    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
  assign key_eq    = key_valid && (key_code == KEY_EQ);
  assign key_clr   = key_valid && (key_code == KEY_CLR);

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES);

  logic [CW-1:0] idle_cnt, idle_cnt_n;
  logic          entry_state, to_hit;

  assign entry_state = (state_q == S_OP) || (state_q == S_B);
  // A key on the expiry cycle pre-empts the timeout
  assign to_hit      = entry_state && !key_valid && (idle_cnt == CW'(TO_CYCLES - 1));

  // Idle counter: runs only while waiting for entry keys
  always_comb begin
    idle_cnt_n = '0;
    if (entry_state && !key_valid && !to_hit) idle_cnt_n = idle_cnt + CW'(1);
  end

  // Idle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_cnt_n;
  end

  assign clear_c = (key_clr && (state_q != S_CALC)) || to_hit;
`else
  assign clear_c = key_clr && (state_q != S_CALC);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    a_n         = a_data;
    b_n         = b_data;
    op_n        = op_sel;
    b_set_n     = b_set;
    result_n    = result;
    res_valid_n = res_valid;

    if (clear_c) begin
      state_n     = S_A;
      a_n         = '0;
      b_n         = '0;
      op_n        = 1'b0;
      b_set_n     = 1'b0;
      result_n    = '0;
      res_valid_n = 1'b0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (key_digit) begin
            a_n     = key_code;
            state_n = S_OP;
          end
        end
        S_OP: begin
          if (key_digit) begin
            a_n = key_code;
          end else if (key_op) begin
            op_n    = (key_code == KEY_SUB);
            state_n = S_B;
          end
        end
        S_B: begin
          if (key_digit) begin
            b_n     = key_code;
            b_set_n = 1'b1;
          end else if (key_op) begin
            op_n = (key_code == KEY_SUB);
          end else if (key_eq && b_set) begin
            state_n = S_CALC;
          end
        end
        S_CALC: begin
          // Operands held one full cycle so the datapath result is settled
          result_n    = res_in;
          res_valid_n = 1'b1;
          state_n     = S_SHOW;
        end
        S_SHOW: begin
          if (key_digit) begin
            a_n         = key_code;
            b_n         = '0;
            b_set_n     = 1'b0;
            res_valid_n = 1'b0;
            state_n     = S_OP;
          end
        end
        default: state_n = S_A;
      endcase
    end

    neg_n = result_n[5] & res_valid_n;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_A;
      a_data    <= '0;
      b_data    <= '0;
      op_sel    <= 1'b0;
      b_set     <= 1'b0;
      result    <= '0;
      res_valid <= 1'b0;
      neg       <= 1'b0;
    end else begin
      state_q   <= state_n;
      a_data    <= a_n;
      b_data    <= b_n;
      op_sel    <= op_n;
      b_set     <= b_set_n;
      result    <= result_n;
      res_valid <= res_valid_n;
      neg       <= neg_n;
    end
  end

  assign state = 3'(state_q);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed vector table, corner-case sequences and randomized
// keypad traffic checked against a calculator-level reference model.
module tb_calc_seq_ctrl;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [5:0] res_in;
  logic [3:0] a_data, b_data;
  logic       op_sel;
  logic [5:0] result;
  logic       res_valid, neg;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  calc_seq_ctrl #(.TO_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .res_in    (res_in),
    .a_data    (a_data),
    .b_data    (b_data),
    .op_sel    (op_sel),
    .result    (result),
    .res_valid (res_valid),
    .neg       (neg),
    .state     (state)
  );

  always #5 clk = ~clk;

  // External combinational add/sub datapath
  assign res_in = op_sel ? (6'(a_data) - 6'(b_data)) : (6'(a_data) + 6'(b_data));

  typedef struct {
    logic       kv;
    logic [3:0] code;
    logic [2:0] st;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [5:0] res;
    logic       rv;
    logic       ng;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic kv, logic [3:0] code, logic [2:0] st, logic [3:0] a,
                              logic [3:0] b, logic op, logic [5:0] res, logic rv, logic ng);
    vec_t v;
    v.kv = kv; v.code = code; v.st = st; v.a = a; v.b = b;
    v.op = op; v.res = res; v.rv = rv; v.ng = ng;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input int a, input int b,
                          input int op, input int res, input int rv, input int ng);
    chk({tag, ".state"},     int'(state),     st);
    chk({tag, ".a_data"},    int'(a_data),    a);
    chk({tag, ".b_data"},    int'(b_data),    b);
    chk({tag, ".op_sel"},    int'(op_sel),    op);
    chk({tag, ".result"},    int'(result),    res);
    chk({tag, ".res_valid"}, int'(res_valid), rv);
    chk({tag, ".neg"},       int'(neg),       ng);
  endtask

  task automatic apply(input logic kv, input logic [3:0] code);
    key_valid = kv;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Calculator-level reference: phase 0 wait A, 1 have A, 2 have op, 3 compute, 4 show
  int m_ph, m_a, m_b, m_op, m_bset, m_res, m_rv, m_idle;

  task automatic model_clear();
    m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_bset = 0; m_res = 0; m_rv = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] c);
    bit dig, opk, eqk, expire;
    dig    = kv && (c <= 4'd9);
    opk    = kv && (c == 4'hA || c == 4'hB);
    eqk    = kv && (c == 4'hE);
    expire = 1'b0;
`ifdef CALC_TIMEOUT_EN
    if ((m_ph == 1 || m_ph == 2) && !kv) begin
      if (m_idle == int'(TO) - 1) expire = 1'b1;
      else m_idle++;
    end else begin
      m_idle = 0;
    end
`endif
    if ((kv && c == 4'hF && m_ph != 3) || expire) begin
      model_clear();
    end else if (m_ph == 3) begin
      m_res = (m_op != 0 ? m_a - m_b : m_a + m_b) & 63;
      m_rv  = 1;
      m_ph  = 4;
    end else if (dig) begin
      case (m_ph)
        0: begin m_a = int'(c); m_ph = 1; end
        1: m_a = int'(c);
        2: begin m_b = int'(c); m_bset = 1; end
        4: begin m_a = int'(c); m_b = 0; m_bset = 0; m_rv = 0; m_ph = 1; end
        default: ;
      endcase
    end else if (opk && (m_ph == 1 || m_ph == 2)) begin
      m_op = (c == 4'hB) ? 1 : 0;
      m_ph = 2;
    end else if (eqk && m_ph == 2 && m_bset != 0) begin
      m_ph = 3;
    end
  endtask

  // Global time limit so the bench can never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed table: key then expected outputs after the capturing edge
    vecs.push_back(mk(1, 4'hA, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hD, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h3, 1, 3, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hB, 2, 3, 0, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h5, 2, 3, 5, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 3, 3, 5, 1, 6'h00, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4, 3, 5, 1, 6'h3E, 1, 1));
    vecs.push_back(mk(1, 4'hE, 4, 3, 5, 1, 6'h3E, 1, 1));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h9, 1, 9, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hA, 2, 9, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h7, 2, 9, 7, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 3, 9, 7, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4, 9, 7, 0, 6'h10, 1, 0));
    vecs.push_back(mk(1, 4'h2, 1, 2, 0, 0, 6'h10, 0, 0));
    vecs.push_back(mk(1, 4'hE, 1, 2, 0, 0, 6'h10, 0, 0));
    vecs.push_back(mk(1, 4'h8, 1, 8, 0, 0, 6'h10, 0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h4, 1, 4, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hA, 2, 4, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 2, 4, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h1, 2, 4, 1, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 3, 4, 1, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4, 4, 1, 0, 6'h05, 1, 0));
    vecs.push_back(mk(1, 4'h7, 1, 7, 0, 0, 6'h05, 0, 0));
    vecs.push_back(mk(1, 4'hA, 2, 7, 0, 0, 6'h05, 0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h5, 1, 5, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hC, 1, 5, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hB, 2, 5, 0, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hD, 2, 5, 0, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hA, 2, 5, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h2, 2, 5, 2, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 3, 5, 2, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4, 5, 2, 0, 6'h07, 1, 0));
    vecs.push_back(mk(1, 4'hC, 4, 5, 2, 0, 6'h07, 1, 0));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h1, 1, 1, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hB, 2, 1, 0, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'h4, 2, 1, 4, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hE, 3, 1, 4, 1, 6'h00, 0, 0));
    vecs.push_back(mk(1, 4'hF, 4, 1, 4, 1, 6'h3D, 1, 1));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 6'h00, 0, 0));

    do_reset();
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].kv, vecs[i].code);
      chk_outs($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].a), int'(vecs[i].b),
               int'(vecs[i].op), int'(vecs[i].res), int'(vecs[i].rv), int'(vecs[i].ng));
    end

    // Async reset asserted mid-entry clears outputs before the next edge
    apply(1, 4'h8);
    apply(1, 4'hB);
    apply(1, 4'h3);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef CALC_TIMEOUT_EN
    // Idle timeout: clear after TO idle cycles in S_OP
    apply(1, 4'h6);
    for (int i = 0; i < int'(TO) - 1; i++) apply(0, 4'h0);
    chk("to_before.state", int'(state), 1);
    apply(0, 4'h0);
    chk_outs("to_expire", 0, 0, 0, 0, 0, 0, 0);
    // Key on the expiry cycle is accepted and restarts the count
    apply(1, 4'h6);
    for (int i = 0; i < int'(TO) - 1; i++) apply(0, 4'h0);
    apply(1, 4'h3);
    chk_outs("to_keywin", 1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) apply(0, 4'h0);
    chk("to_restart.state", int'(state), 1);
    apply(0, 4'h0);
    chk("to_restart_exp.state", int'(state), 0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      logic       kv;
      logic [3:0] c;
      kv = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      model_step(kv, c);
      apply(kv, c);
      chk_outs($sformatf("rnd%0d", i), m_ph, m_a, m_b, m_op, m_res, m_rv,
               ((m_res >> 5) & 1) & m_rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
